// File: rtl/step_phase_pkg.sv
// rtl/step_phase_pkg.sv - phase pattern constants, FSM states and pattern decode
package step_phase_pkg;

    localparam logic [3:0] PAT_IDX0 = 4'b0110;
    localparam logic [3:0] PAT_IDX1 = 4'b0101;
    localparam logic [3:0] PAT_IDX2 = 4'b1001;
    localparam logic [3:0] PAT_IDX3 = 4'b1010;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } decode_t;

    function automatic decode_t decode_pattern(input logic [3:0] pat);
        decode_t d;
        d.valid = 1'b1;
        d.idx   = 2'd0;
        case (pat)
            PAT_IDX0: d.idx = 2'd0;
            PAT_IDX1: d.idx = 2'd1;
            PAT_IDX2: d.idx = 2'd2;
            PAT_IDX3: d.idx = 2'd3;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_sync_filter.sv
// rtl/phase_sync_filter.sv - 2-flop synchronizers plus stability filter with accept strobe
module phase_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lines,
    output logic [3:0] pattern,
    output logic       accept
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // cnt_next is the number of consecutive identical samples including this cycle's
    always_comb begin
        cnt_next = cnt;
        if (sync2 != cand) begin
            cnt_next = CW'(1);
        end else if (cnt != CW'(STABLE_CYCLES)) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 4'd0;
            sync2   <= 4'd0;
            cand    <= 4'd0;
            cnt     <= '0;
            pattern <= 4'd0;
            accept  <= 1'b0;
        end else begin
            sync1  <= lines;
            sync2  <= sync1;
            cand   <= sync2;
            cnt    <= cnt_next;
            accept <= 1'b0;
            if ((cnt_next == CW'(STABLE_CYCLES)) && (sync2 != pattern)) begin
                accept  <= 1'b1;
                pattern <= sync2;
            end
        end
    end

endmodule

// File: rtl/step_phase_decoder.sv
// rtl/step_phase_decoder.sv - 4-phase stepper bus monitor: step decode, position, period, errors
module step_phase_decoder
    import step_phase_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int PER_W         = 24,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    A_phase,
    input  logic                    B_phase,
    input  logic                    C_phase,
    input  logic                    D_phase,
    input  logic                    err_clr,
    output logic                    step_fwd,
    output logic                    step_rev,
    output logic signed [POS_W-1:0] position,
    output logic [1:0]              phase_idx,
    output logic                    locked,
    output logic [PER_W-1:0]        step_period,
    output logic                    err_invalid,
    output logic                    err_skip
);

    logic [3:0]       acc_pat;
    logic             accept;
    decode_t          dec;
    logic [1:0]       delta;
    state_t           state;
    logic [PER_W-1:0] per_cnt;

    phase_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .lines  ({A_phase, B_phase, C_phase, D_phase}),
        .pattern(acc_pat),
        .accept (accept)
    );

    always_comb begin
        dec   = decode_pattern(acc_pat);
        delta = dec.idx - phase_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNLOCKED;
            step_fwd    <= 1'b0;
            step_rev    <= 1'b0;
            position    <= '0;
            phase_idx   <= 2'd0;
            locked      <= 1'b0;
            step_period <= '0;
            per_cnt     <= '0;
            err_invalid <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            step_fwd <= 1'b0;
            step_rev <= 1'b0;

            // a set event in the same cycle as err_clr keeps the flag high
            if (accept && !dec.valid) begin
                err_invalid <= 1'b1;
            end else if (err_clr) begin
                err_invalid <= 1'b0;
            end
            if (accept && dec.valid && (state == LOCKED) && (delta == 2'd2)) begin
                err_skip <= 1'b1;
            end else if (err_clr) begin
                err_skip <= 1'b0;
            end

            if ((state == LOCKED) && (per_cnt != {PER_W{1'b1}})) begin
                per_cnt <= per_cnt + PER_W'(1);
            end

            case (state)
                UNLOCKED: begin
                    if (accept && dec.valid) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        phase_idx <= dec.idx;
                        per_cnt   <= PER_W'(1);
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (!dec.valid) begin
                            state  <= UNLOCKED;
                            locked <= 1'b0;
                        end else begin
                            case (delta)
                                2'd1: begin
                                    step_fwd    <= 1'b1;
                                    position    <= position + POS_W'(1);
                                    phase_idx   <= dec.idx;
                                    step_period <= per_cnt;
                                    per_cnt     <= PER_W'(1);
                                end
                                2'd3: begin
                                    step_rev    <= 1'b1;
                                    position    <= position - POS_W'(1);
                                    phase_idx   <= dec.idx;
                                    step_period <= per_cnt;
                                    per_cnt     <= PER_W'(1);
                                end
                                2'd2: begin
                                    phase_idx <= dec.idx;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_phase_decoder.sv
// tb/tb_step_phase_decoder.sv - table-driven bench for step_phase_decoder
module tb_step_phase_decoder;

    localparam int S = 4;

    logic clk;
    logic rst;
    logic a_ph, b_ph, c_ph, d_ph;
    logic err_clr;

    logic               step_fwd, step_rev;
    logic signed [15:0] position;
    logic [1:0]         phase_idx;
    logic               locked;
    logic [23:0]        step_period;
    logic               err_invalid, err_skip;

    logic               step_fwd4, step_rev4;
    logic signed [3:0]  position4;
    logic [1:0]         phase_idx4;
    logic               locked4;
    logic [23:0]        step_period4;
    logic               err_invalid4, err_skip4;

    step_phase_decoder #(.POS_W(16), .PER_W(24), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .A_phase(a_ph), .B_phase(b_ph), .C_phase(c_ph), .D_phase(d_ph),
        .err_clr(err_clr),
        .step_fwd(step_fwd), .step_rev(step_rev), .position(position),
        .phase_idx(phase_idx), .locked(locked), .step_period(step_period),
        .err_invalid(err_invalid), .err_skip(err_skip)
    );

    step_phase_decoder #(.POS_W(4), .PER_W(24), .STABLE_CYCLES(S)) dut4 (
        .clk(clk), .rst(rst),
        .A_phase(a_ph), .B_phase(b_ph), .C_phase(c_ph), .D_phase(d_ph),
        .err_clr(err_clr),
        .step_fwd(step_fwd4), .step_rev(step_rev4), .position(position4),
        .phase_idx(phase_idx4), .locked(locked4), .step_period(step_period4),
        .err_invalid(err_invalid4), .err_skip(err_skip4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int fwd_cnt = 0;
    int rev_cnt = 0;
    always @(negedge clk) begin
        if (step_fwd) fwd_cnt++;
        if (step_rev) rev_cnt++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p);
        {a_ph, b_ph, c_ph, d_ph} = p;
    endtask

    typedef struct {
        logic [3:0] pat;
        int         hold;
        int         fwd;
        int         rev;
        int         pos;
        int         pos4;
        int         idx;
        int         lck;
        int         inv;
        int         skp;
        int         per;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //              pat      hold fwd rev pos pos4 idx lck inv skp per
        vecs[0]  = '{4'b1001, 100, 2, 0, 2, 2, 2, 1, 0, 0, 100};
        vecs[1]  = '{4'b1010, 100, 3, 0, 3, 3, 3, 1, 0, 0, 100};
        vecs[2]  = '{4'b0110, 100, 4, 0, 4, 4, 0, 1, 0, 0, 100};
        vecs[3]  = '{4'b0101, 100, 5, 0, 5, 5, 1, 1, 0, 0, 100};
        vecs[4]  = '{4'b1001, 100, 6, 0, 6, 6, 2, 1, 0, 0, 100};
        vecs[5]  = '{4'b1010, 100, 7, 0, 7, 7, 3, 1, 0, 0, 100};
        vecs[6]  = '{4'b0110, 100, 8, 0, 8, -8, 0, 1, 0, 0, 100};
        vecs[7]  = '{4'b1010, 100, 8, 1, 7, 7, 3, 1, 0, 0, 100};
        vecs[8]  = '{4'b1001, 100, 8, 2, 6, 6, 2, 1, 0, 0, 100};
        vecs[9]  = '{4'b0101, 100, 8, 3, 5, 5, 1, 1, 0, 0, 100};
        vecs[10] = '{4'b1111,   2, 8, 3, 5, 5, 1, 1, 0, 0, 100};
        vecs[11] = '{4'b0101,  20, 8, 3, 5, 5, 1, 1, 0, 0, 100};
        vecs[12] = '{4'b1111,  20, 8, 3, 5, 5, 1, 0, 1, 0, 100};
        vecs[13] = '{4'b0110,  20, 8, 3, 5, 5, 0, 1, 1, 0, 100};

        rst = 1'b1;
        err_clr = 1'b0;
        drive(4'b0000);
        tick(3);
        chk("rst_step_fwd", int'(step_fwd), 0);
        chk("rst_step_rev", int'(step_rev), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_phase_idx", int'(phase_idx), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_step_period", int'(step_period), 0);
        chk("rst_err_invalid", int'(err_invalid), 0);
        chk("rst_err_skip", int'(err_skip), 0);
        rst = 1'b0;
        tick(5);

        // lock latency: visible after edge N+2+S
        drive(4'b0110);
        tick(S + 2);
        chk("lock_early", int'(locked), 0);
        tick(1);
        chk("lock_on_time", int'(locked), 1);
        chk("lock_idx", int'(phase_idx), 0);
        chk("lock_pos", int'(position), 0);
        tick(100 - S - 3);
        chk("lock_no_pulse", fwd_cnt + rev_cnt, 0);

        // first step: exact latency and one-cycle width
        drive(4'b0101);
        tick(S + 2);
        chk("step_early", int'(step_fwd), 0);
        tick(1);
        chk("step_on_time", int'(step_fwd), 1);
        chk("step_pos", int'(position), 1);
        tick(1);
        chk("step_width", int'(step_fwd), 0);
        tick(100 - S - 4);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pat);
            tick(vecs[i].hold);
            chk($sformatf("row%0d_fwd", i), fwd_cnt, vecs[i].fwd);
            chk($sformatf("row%0d_rev", i), rev_cnt, vecs[i].rev);
            chk($sformatf("row%0d_pos", i), int'(position), vecs[i].pos);
            chk($sformatf("row%0d_pos4", i), int'(position4), vecs[i].pos4);
            chk($sformatf("row%0d_idx", i), int'(phase_idx), vecs[i].idx);
            chk($sformatf("row%0d_locked", i), int'(locked), vecs[i].lck);
            chk($sformatf("row%0d_err_invalid", i), int'(err_invalid), vecs[i].inv);
            chk($sformatf("row%0d_err_skip", i), int'(err_skip), vecs[i].skp);
            chk($sformatf("row%0d_period", i), int'(step_period), vecs[i].per);
        end

        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr_err_invalid", int'(err_invalid), 0);

        // two-index jump idx0 -> idx2
        drive(4'b1001);
        tick(20);
        chk("skip_flag", int'(err_skip), 1);
        chk("skip_idx", int'(phase_idx), 2);
        chk("skip_pos", int'(position), 5);
        chk("skip_locked", int'(locked), 1);
        chk("skip_no_pulse", fwd_cnt + rev_cnt, 11);
        chk("skip_period", int'(step_period), 100);

        // new skip registered in the same cycle as err_clr
        drive(4'b0110);
        tick(S + 2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("skipclr_flag", int'(err_skip), 1);
        chk("skipclr_idx", int'(phase_idx), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr_err_skip", int'(err_skip), 0);
        tick(10);

        // reset mid-operation: next pattern only relocks
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_pos", int'(position), 0);
        tick(20);
        chk("relock_locked", int'(locked), 1);
        chk("relock_idx", int'(phase_idx), 0);
        chk("relock_pos", int'(position), 0);
        chk("relock_no_pulse", fwd_cnt + rev_cnt, 11);
        drive(4'b0101);
        tick(20);
        chk("post_rst_step_pos", int'(position), 1);
        chk("post_rst_step_fwd", fwd_cnt, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
